// File: rtl/mdr_seq_engine_pkg.sv
// Shared types and constants for the MDR sequential multiply/divide/root engine.
package pkg_system_mdr;

  localparam int MDR_DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2,
    RSVD = 2'd3
  } op_select_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdr_state_t;

  // Square root resolves two radicand bits per step, so it needs half the iterations.
  function automatic int iter_count(input op_select_t op, input int dw);
    return (op == ROOT) ? dw / 2 : dw;
  endfunction

endpackage

// File: rtl/mdr_seq_engine_addsub.sv
// Combinational add/subtract stage shared by the multiply, divide and root iterations.
module mdr_addsub_stage #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         borrow
);

  logic [W:0] full;

  // For subtraction the extra top bit is set exactly when a < b.
  always_comb begin
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
  end

  assign res    = full[W-1:0];
  assign borrow = full[W];

endmodule

// File: rtl/mdr_seq_engine.sv
// Sequential multiply / restoring divide / restoring square-root engine, one iteration per clock.
// Define MDR_SIGNED_EN to add the i_signed port and two's-complement MULT/DIV support.
module mdr_seq_engine
  import pkg_system_mdr::*;
#(
  parameter int DW = MDR_DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [DW-1:0]   i_data_x,
  input  logic [DW-1:0]   i_data_y,
`ifdef MDR_SIGNED_EN
  input  logic            i_signed,
`endif
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_result,
  output logic [DW-1:0]   o_remainder,
  output logic            o_error
);

  localparam int CW = $clog2(DW) + 1;
  localparam int AW = DW + 2;
  localparam int HW = DW / 2;

  mdr_state_t state, state_next;
  op_select_t op_in, op;

  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   shf;
  logic [DW-1:0]   opy;
  logic [HW-1:0]   root;
  logic            early;
  logic            neg_res;
  logic            neg_rem;
  logic            signed_div;

  logic            sgn_in;
  logic            x_neg;
  logic            y_neg;
  logic            early_in;
  logic [DW-1:0]   mag_x;
  logic [DW-1:0]   mag_y;

  logic [AW-1:0]   as_a;
  logic [AW-1:0]   as_b;
  logic [AW-1:0]   as_res;
  logic            as_sub;
  logic            as_borrow;
  logic            unused_sum_msb;

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo;
  logic [2*DW-1:0] fin_result;
  logic [DW-1:0]   fin_rem;
  logic            fin_err;

  assign op_in = op_select_t'(i_op);

`ifdef MDR_SIGNED_EN
  assign sgn_in = i_signed && (op_in != RSVD);
`else
  assign sgn_in = 1'b0;
`endif

  // Signed operands are reduced to magnitudes before CALC; signs are reapplied in DONE.
  assign x_neg    = sgn_in && i_data_x[DW-1];
  assign y_neg    = sgn_in && (op_in != ROOT) && i_data_y[DW-1];
  assign mag_x    = x_neg ? -i_data_x : i_data_x;
  assign mag_y    = y_neg ? -i_data_y : i_data_y;
  assign early_in = (op_in == RSVD) ||
                    ((op_in == DIV) && (i_data_y == '0)) ||
                    ((op_in == ROOT) && x_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = early_in ? DONE : CALC;
      end
      CALC: begin
        o_busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        o_busy     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand selection for the shared adder: add for MULT, trial subtract for DIV and ROOT.
  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    case (op)
      MULT: begin
        as_a = {2'b00, acc};
        as_b = shf[0] ? {2'b00, opy} : '0;
      end
      DIV: begin
        as_a   = {1'b0, acc, shf[DW-1]};
        as_b   = {2'b00, opy};
        as_sub = 1'b1;
      end
      ROOT: begin
        as_a   = AW'({acc[HW:0], shf[DW-1:DW-2]});
        as_b   = AW'({root, 2'b01});
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  mdr_addsub_stage #(
    .W(AW)
  ) u_addsub (
    .a      (as_a),
    .b      (as_b),
    .sub    (as_sub),
    .res    (as_res),
    .borrow (as_borrow)
  );

  assign unused_sum_msb = as_res[AW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= MULT;
      cnt        <= '0;
      acc        <= '0;
      shf        <= '0;
      opy        <= '0;
      root       <= '0;
      early      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      signed_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            op         <= op_in;
            early      <= early_in;
            neg_res    <= x_neg ^ y_neg;
            neg_rem    <= x_neg;
            signed_div <= sgn_in && (op_in == DIV);
            cnt        <= early_in ? '0 : CW'(iter_count(op_in, DW));
            acc        <= '0;
            root       <= '0;
            opy        <= (op_in == MULT) ? mag_x : mag_y;
            // Early exits keep the raw dividend so divide-by-zero can report it.
            if (early_in)            shf <= i_data_x;
            else if (op_in == MULT)  shf <= mag_y;
            else                     shf <= mag_x;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          case (op)
            MULT: begin
              acc <= as_res[DW:1];
              shf <= {as_res[0], shf[DW-1:1]};
            end
            DIV: begin
              acc <= as_borrow ? as_a[DW-1:0] : as_res[DW-1:0];
              shf <= {shf[DW-2:0], ~as_borrow};
            end
            ROOT: begin
              acc  <= as_borrow ? as_a[DW-1:0] : as_res[DW-1:0];
              shf  <= {shf[DW-3:0], 2'b00};
              root <= {root[HW-2:0], ~as_borrow};
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Final result formatting, registered into the outputs while in DONE.
  always_comb begin
    fin_result = '0;
    fin_rem    = '0;
    fin_err    = 1'b0;
    prod       = {acc, shf};
    quo        = shf;
    if (early) begin
      fin_err = 1'b1;
      if (op == DIV) begin
        fin_result = {{DW{1'b0}}, {DW{1'b1}}};
        fin_rem    = shf;
      end
    end else begin
      case (op)
        MULT: fin_result = neg_res ? -prod : prod;
        DIV: begin
          if (neg_res) quo = -shf;
          // Only -2^(DW-1) / -1 yields a positive quotient magnitude with the top bit set.
          if (signed_div && !neg_res && shf[DW-1]) begin
            fin_err = 1'b1;
            quo     = {1'b0, {(DW-1){1'b1}}};
          end
          fin_result = {{DW{1'b0}}, quo};
          fin_rem    = neg_rem ? -acc : acc;
        end
        ROOT: begin
          fin_result = {{(2*DW-HW){1'b0}}, root};
          fin_rem    = acc;
        end
        default: fin_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_done      <= 1'b0;
      o_result    <= '0;
      o_remainder <= '0;
      o_error     <= 1'b0;
    end else begin
      o_done <= (state == DONE);
      if (state == DONE) begin
        o_result    <= fin_result;
        o_remainder <= fin_rem;
        o_error     <= fin_err;
      end
    end
  end

endmodule

// File: tb/tb_mdr_seq_engine.sv
// Self-checking bench for mdr_seq_engine: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_mdr_seq_engine;

  localparam int DW = 16;
`ifdef MDR_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'd0;
  logic [DW-1:0] i_data_x = '0;
  logic [DW-1:0] i_data_y = '0;
  logic          i_signed = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic [31:0]   o_result;
  logic [15:0]   o_remainder;
  logic          o_error;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  mdr_seq_engine #(
    .DW(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_data_x    (i_data_x),
    .i_data_y    (i_data_y),
`ifdef MDR_SIGNED_EN
    .i_signed    (i_signed),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_remainder (o_remainder),
    .o_error     (o_error)
  );

  // Reference model: plain integer arithmetic, latency counted from the start edge.
  function automatic void model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                                input logic sg, output logic [31:0] r, output logic [15:0] rm,
                                output logic e, output int lat);
    int sx, sy, q, m, rt;
    r   = '0;
    rm  = '0;
    e   = 1'b0;
    lat = DW + 1;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    case (op)
      2'd0: begin
        if (sg) r = 32'(sx * sy);
        else    r = 32'(x) * 32'(y);
      end
      2'd1: begin
        if (y == 16'd0) begin
          e = 1'b1; r = 32'h0000FFFF; rm = x; lat = 1;
        end else if (sg) begin
          q = sx / sy;
          m = sx % sy;
          if (q > 32767) begin e = 1'b1; q = 32767; end
          r  = {16'h0000, q[15:0]};
          rm = m[15:0];
        end else begin
          r  = 32'(x / y);
          rm = x % y;
        end
      end
      2'd2: begin
        if (sg && x[15]) begin
          e = 1'b1; lat = 1;
        end else begin
          rt = 0;
          while ((rt + 1) * (rt + 1) <= int'(x)) rt++;
          r   = 32'(rt);
          rm  = 16'(int'(x) - rt * rt);
          lat = DW / 2 + 1;
        end
      end
      default: begin
        e = 1'b1; lat = 1;
      end
    endcase
  endfunction

  // Drives one request and waits (bounded) for o_done; lat stays -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic sg, output int lat);
    @(negedge clk);
    i_op = op; i_data_x = x; i_data_y = y; i_signed = sg; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_count++;
    if ({o_busy, o_done, o_error, o_result, o_remainder} !== '0)
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b res=%h rem=%h expected all zero",
               o_busy, o_done, o_error, o_result, o_remainder);
    else pass_count++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_count++;
    if (o_busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b expected 0", o_busy);
    else pass_count++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [15:0] xs  [12] = '{16'd300, 16'd1000, 16'd55, 16'd1000, 16'hFFFF, 16'd77,
                              16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'd0, 16'd0};
    logic [15:0] ys  [12] = '{16'd200, 16'd7, 16'd0, 16'd0, 16'd0, 16'd3,
                              16'hFFFF, 16'd9, 16'd1, 16'd0, 16'd1234, 16'd3};
    logic [31:0] er;
    logic [15:0] erm;
    logic        ee;
    int          el, lat;
    for (int i = 0; i < 12; i++) begin
      model(ops[i], xs[i], ys[i], 1'b0, er, erm, ee, el);
      run_op(ops[i], xs[i], ys[i], 1'b0, lat);
      check_count++;
      if (lat !== el) $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, el);
      else pass_count++;
      check_count++;
      if (o_result !== er) $display("[TB] FAIL directed%0d_result: got %h expected %h", i, o_result, er);
      else pass_count++;
      check_count++;
      if (o_remainder !== erm) $display("[TB] FAIL directed%0d_rem: got %h expected %h", i, o_remainder, erm);
      else pass_count++;
      check_count++;
      if (o_error !== ee) $display("[TB] FAIL directed%0d_error: got %b expected %b", i, o_error, ee);
      else pass_count++;
    end
    run_op(2'd0, 16'd300, 16'd200, 1'b0, lat);
    check_count++;
    if (o_result !== 32'h0000EA60) $display("[TB] FAIL mult_plan: got %h expected 0000ea60", o_result);
    else pass_count++;
  endtask

  task automatic test_busy_ignore();
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic [31:0] res = '0;
    @(negedge clk);
    i_op = 2'd0; i_data_x = 16'd300; i_data_y = 16'd200; i_signed = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (o_done) begin
        done_cnt++;
        done_cyc = c;
        res = o_result;
      end
      if (c == 2 || c == 9) begin
        i_start  = 1'b1;
        i_op     = 2'd1;
        i_data_x = 16'($urandom);
        i_data_y = 16'($urandom_range(1, 50));
      end
    end
    check_count++;
    if (done_cnt !== 1) $display("[TB] FAIL busy_done_count: got %0d expected 1", done_cnt);
    else pass_count++;
    check_count++;
    if (done_cyc !== 17) $display("[TB] FAIL busy_done_cycle: got %0d expected 17", done_cyc);
    else pass_count++;
    check_count++;
    if (res !== 32'(300 * 200)) $display("[TB] FAIL busy_result: got %h expected %h", res, 32'(300 * 200));
    else pass_count++;
  endtask

  task automatic test_hold();
    int lat;
    run_op(2'd0, 16'd1234, 16'd567, 1'b0, lat);
    @(negedge clk);
    i_op = 2'd1; i_data_x = 16'd9999; i_data_y = 16'd13; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_count++;
    if (o_result !== 32'(1234 * 567))
      $display("[TB] FAIL hold_result: got %h expected %h", o_result, 32'(1234 * 567));
    else pass_count++;
    check_count++;
    if (o_busy !== 1'b1) $display("[TB] FAIL hold_busy: got %b expected 1", o_busy);
    else pass_count++;
    lat = -1;
    for (int c = 6; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (o_done) begin lat = c; break; end
    end
    check_count++;
    if (lat !== 17 || o_result !== 32'(9999 / 13) || o_remainder !== 16'(9999 % 13))
      $display("[TB] FAIL hold_next_div: got lat=%0d q=%0d r=%0d expected lat=17 q=%0d r=%0d",
               lat, o_result, o_remainder, 9999 / 13, 9999 % 13);
    else pass_count++;
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    int lat;
    @(negedge clk);
    i_op = 2'd1; i_data_x = 16'd1000; i_data_y = 16'd7; i_signed = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_count++;
    if ({o_busy, o_done, o_error, o_result, o_remainder} !== '0)
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b err=%b res=%h rem=%h expected all zero",
               o_busy, o_done, o_error, o_result, o_remainder);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (o_done) done_cnt++;
    end
    check_count++;
    if (done_cnt !== 0) $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt);
    else pass_count++;
    run_op(2'd1, 16'd1000, 16'd7, 1'b0, lat);
    check_count++;
    if (lat !== 17 || o_result !== 32'd142 || o_remainder !== 16'd6 || o_error !== 1'b0)
      $display("[TB] FAIL abort_restart: got lat=%0d q=%0d r=%0d e=%b expected lat=17 q=142 r=6 e=0",
               lat, o_result, o_remainder, o_error);
    else pass_count++;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] x, y;
    logic        sg;
    logic [31:0] er;
    logic [15:0] erm;
    logic        ee;
    int          el, lat;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      x  = 16'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      sg = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
      model(op, x, y, sg, er, erm, ee, el);
      run_op(op, x, y, sg, lat);
      check_count++;
      if (lat !== el || o_result !== er || o_remainder !== erm || o_error !== ee)
        $display("[TB] FAIL random%0d op=%0d x=%h y=%h s=%b: got lat=%0d res=%h rem=%h err=%b expected lat=%0d res=%h rem=%h err=%b",
                 i, op, x, y, sg, lat, o_result, o_remainder, o_error, el, er, erm, ee);
      else pass_count++;
    end
  endtask

`ifdef MDR_SIGNED_EN
  task automatic test_signed();
    logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [15:0] xs  [6] = '{16'hFED4, 16'h8000, 16'hFFFC, 16'hFFF9, 16'd100, 16'h8000};
    logic [15:0] ys  [6] = '{16'd200, 16'hFFFF, 16'd0, 16'd2, 16'hFFF9, 16'h8000};
    logic [31:0] er;
    logic [15:0] erm;
    logic        ee;
    int          el, lat;
    for (int i = 0; i < 6; i++) begin
      model(ops[i], xs[i], ys[i], 1'b1, er, erm, ee, el);
      run_op(ops[i], xs[i], ys[i], 1'b1, lat);
      check_count++;
      if (lat !== el || o_result !== er || o_remainder !== erm || o_error !== ee)
        $display("[TB] FAIL signed%0d: got lat=%0d res=%h rem=%h err=%b expected lat=%0d res=%h rem=%h err=%b",
                 i, lat, o_result, o_remainder, o_error, el, er, erm, ee);
      else pass_count++;
    end
    run_op(2'd0, 16'hFED4, 16'd200, 1'b1, lat);
    check_count++;
    if (o_result !== 32'hFFFF15A0) $display("[TB] FAIL signed_mult_plan: got %h expected ffff15a0", o_result);
    else pass_count++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_hold();
    test_reset_abort();
    test_random();
`ifdef MDR_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
